// File: rtl/axi_inf_write_state_core.sv
// AXI4 write-channel master for the VDMA write path: one burst per request,
// AW issue, W streaming with WLAST from the upstream FIFO, then B consume.
module axi_inf_write_state_core #(
  parameter int IDSIZE = 4,
  parameter int ID     = 0,
  parameter int LSIZE  = 9,
  parameter int ASIZE  = 29,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic                 write_req,
  input  logic [LSIZE-1:0]     req_len,
  input  logic [ASIZE-1:0]     req_addr,
  output logic                 req_resp,
  output logic                 req_done,
  output logic                 resp_err,
  input  logic                 pend_in,
  output logic                 pend_out,
  input  logic [DSIZE-1:0]     idata,
  input  logic                 ivalid,
  output logic                 iready,
  output logic [IDSIZE-1:0]    axi_awid,
  output logic [ASIZE-1:0]     axi_awaddr,
  output logic [LSIZE-1:0]     axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awlock,
  output logic [3:0]           axi_awcache,
  output logic [2:0]           axi_awprot,
  output logic [3:0]           axi_awqos,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [DSIZE-1:0]     axi_wdata,
  output logic [DSIZE/8-1:0]   axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [IDSIZE-1:0]    axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready
);

  localparam int BSIZE = $clog2(DSIZE / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ASIZE-1:0]   r_awaddr;
  logic [LSIZE-1:0]   r_awlen;
  logic [LSIZE-1:0]   r_cnt;
  logic               r_err;

  logic               w_accept;
  logic               w_wvalid;
  logic               w_whs;
  logic               w_last;
  logic               w_unused;

  assign axi_awid    = IDSIZE'(ID);
  assign axi_awsize  = 3'(BSIZE);
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0011;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_wstrb   = '1;

  // BID carries no information for a single-outstanding master.
  assign w_unused = ^axi_bid;

  assign w_accept = (r_state == S_IDLE) && write_req && !pend_in;
  assign w_wvalid = (r_state == S_DATA) && ivalid;
  assign w_whs    = w_wvalid && axi_wready;
  assign w_last   = (r_cnt == r_awlen) && w_wvalid;

  assign axi_awaddr  = r_awaddr;
  assign axi_awlen   = r_awlen;
  assign axi_awvalid = (r_state == S_ADDR);
  assign axi_wdata   = idata;
  assign axi_wvalid  = w_wvalid;
  assign axi_wlast   = w_last;
  assign iready      = (r_state == S_DATA) && axi_wready;
  assign axi_bready  = (r_state == S_RESP);
  assign req_resp    = w_accept;
  assign req_done    = (r_state == S_DONE);
  assign resp_err    = (r_state == S_DONE) && r_err;
  assign pend_out    = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_RESP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)               w_next = S_ADDR;
      S_ADDR: if (axi_awready)            w_next = S_DATA;
      S_DATA: if (w_whs && w_last)        w_next = S_RESP;
      S_RESP: if (axi_bvalid)             w_next = S_DONE;
      S_DONE:                             w_next = S_IDLE;
      default:                            w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state  <= S_IDLE;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_awaddr <= req_addr;
        r_awlen  <= req_len;
      end
      if ((r_state == S_ADDR) && axi_awready) begin
        r_cnt <= '0;
      end else if (w_whs && !w_last) begin
        // Hold on the final beat so a full-length burst never wraps the counter.
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_RESP) && axi_bvalid) begin
        r_err <= (axi_bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_axi_inf_write_state_core.sv
// Bench for axi_inf_write_state_core: scenario tasks with a beat scoreboard
// and a simple AXI slave / stream source driven on the falling clock edge.
module tb_axi_inf_write_state_core;

  localparam int IDSIZE = 4;
  localparam int LSIZE  = 9;
  localparam int ASIZE  = 29;
  localparam int DSIZE  = 32;

  logic               clk = 1'b0;
  logic               axi_resetn;
  logic               write_req;
  logic [LSIZE-1:0]   req_len;
  logic [ASIZE-1:0]   req_addr;
  logic               req_resp, req_done, resp_err;
  logic               pend_in, pend_out;
  logic [DSIZE-1:0]   idata;
  logic               ivalid, iready;
  logic [IDSIZE-1:0]  axi_awid;
  logic [ASIZE-1:0]   axi_awaddr;
  logic [LSIZE-1:0]   axi_awlen;
  logic [2:0]         axi_awsize;
  logic [1:0]         axi_awburst;
  logic               axi_awlock;
  logic [3:0]         axi_awcache;
  logic [2:0]         axi_awprot;
  logic [3:0]         axi_awqos;
  logic               axi_awvalid, axi_awready;
  logic [DSIZE-1:0]   axi_wdata;
  logic [DSIZE/8-1:0] axi_wstrb;
  logic               axi_wlast, axi_wvalid, axi_wready;
  logic [IDSIZE-1:0]  axi_bid;
  logic [1:0]         axi_bresp;
  logic               axi_bvalid, axi_bready;

  int n_vec = 0;
  int n_err = 0;
  logic [DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0] src_q[$];

  always #5 clk = ~clk;

  axi_inf_write_state_core #(
    .IDSIZE(IDSIZE), .ID(0), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)
  ) dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn),
    .write_req(write_req), .req_len(req_len), .req_addr(req_addr),
    .req_resp(req_resp), .req_done(req_done), .resp_err(resp_err),
    .pend_in(pend_in), .pend_out(pend_out),
    .idata(idata), .ivalid(ivalid), .iready(iready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  // Full burst: request, AW, W beats checked against the scoreboard, B, done.
  task automatic burst(input logic [ASIZE-1:0] addr, input int len, input bit wtog,
                       input int gap_at, input int gap_n, input logic [1:0] bresp,
                       output int beats, output int pops);
    int c;
    bit fin;
    bit el;
    logic [DSIZE-1:0] d;
    beats = 0;
    pops  = 0;
    exp_q.delete();
    src_q.delete();
    for (int i = 0; i <= len; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      src_q.push_back(d);
    end
    @(negedge clk);
    pend_in = 1'b0; write_req = 1'b1; req_addr = addr; req_len = LSIZE'(len);
    #1;
    n_vec++;
    if (req_resp !== 1'b1) begin
      n_err++; $display("FAIL req_resp_accept: got %b want 1", req_resp);
    end
    @(negedge clk);
    write_req = 1'b0;
    #1;
    n_vec++;
    if ({axi_awvalid, pend_out, iready} !== 3'b110 || axi_awaddr !== addr ||
        axi_awlen !== LSIZE'(len) || req_resp !== 1'b0) begin
      n_err++;
      $display("FAIL aw_phase: got awv/pend/irdy=%b%b%b addr=%h len=%0d want 110 addr=%h len=%0d",
               axi_awvalid, pend_out, iready, axi_awaddr, axi_awlen, addr, len);
    end
    c = 0;
    fin = 1'b0;
    while (!fin && c < 4 * len + 40) begin
      @(negedge clk);
      ivalid     = !(c >= gap_at && c < gap_at + gap_n) && (src_q.size() > 0);
      idata      = (src_q.size() > 0) ? src_q[0] : '0;
      axi_wready = wtog ? (c % 2 == 0) : 1'b1;
      #1;
      el = axi_wvalid && (beats == len);
      n_vec++;
      if (axi_awvalid !== 1'b0 || axi_wvalid !== ivalid || iready !== axi_wready ||
          axi_wlast !== el) begin
        n_err++;
        $display("FAIL w_ctrl c=%0d: got awv=%b wv=%b irdy=%b wlast=%b want 0 %b %b %b",
                 c, axi_awvalid, axi_wvalid, iready, axi_wlast, ivalid, axi_wready, el);
      end
      if (ivalid && iready) pops++;
      if (axi_wvalid && axi_wready) begin
        d = exp_q.pop_front();
        void'(src_q.pop_front());
        n_vec++;
        if (axi_wdata !== d) begin
          n_err++; $display("FAIL w_data beat=%0d: got %h want %h", beats, axi_wdata, d);
        end
        beats++;
        if (axi_wlast) fin = 1'b1;
      end
      c++;
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL burst_timeout: got %0d beats want %0d with wlast", beats, len + 1);
    end
    @(negedge clk);
    ivalid = 1'b1; idata = 32'hdeadbeef; axi_bvalid = 1'b0;
    #1;
    n_vec++;
    if ({axi_bready, pend_out, iready, axi_wvalid, req_done} !== 5'b11000) begin
      n_err++;
      $display("FAIL resp_wait: got brdy/pend/irdy/wv/done=%b%b%b%b%b want 11000",
               axi_bready, pend_out, iready, axi_wvalid, req_done);
    end
    @(negedge clk);
    axi_bvalid = 1'b1; axi_bresp = bresp; axi_bid = 4'ha;
    #1;
    n_vec++;
    if (axi_bready !== 1'b1 || req_done !== 1'b0) begin
      n_err++; $display("FAIL b_handshake: got bready=%b done=%b want 1 0", axi_bready, req_done);
    end
    @(negedge clk);
    axi_bvalid = 1'b0; ivalid = 1'b0; axi_bresp = 2'b00;
    #1;
    n_vec++;
    if ({req_done, resp_err, pend_out, axi_bready} !== {1'b1, (bresp != 2'b00), 2'b00}) begin
      n_err++;
      $display("FAIL done_pulse: got done/err/pend/brdy=%b%b%b%b want 1%b00",
               req_done, resp_err, pend_out, axi_bready, (bresp != 2'b00));
    end
  endtask

  task automatic test_reset;
    axi_resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, req_resp, req_done, resp_err,
         pend_out, iready} !== 9'b0 || axi_awaddr !== '0 || axi_awlen !== '0) begin
      n_err++;
      $display("FAIL reset_state: got ctrl=%b addr=%h len=%0d want 0",
               {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, req_resp, req_done,
                resp_err, pend_out, iready}, axi_awaddr, axi_awlen);
    end
    n_vec++;
    if (axi_awid !== 4'd0 || axi_awsize !== 3'b010 || axi_awburst !== 2'b01 ||
        axi_awlock !== 1'b0 || axi_awcache !== 4'b0011 || axi_awprot !== 3'b000 ||
        axi_awqos !== 4'b0000 || axi_wstrb !== 4'hf) begin
      n_err++;
      $display("FAIL constants: got id=%h size=%b burst=%b lock=%b cache=%b prot=%b qos=%b strb=%h want 0 010 01 0 0011 000 0000 f",
               axi_awid, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot,
               axi_awqos, axi_wstrb);
    end
    @(negedge clk);
    axi_resetn = 1'b1;
  endtask

  task automatic test_basic;
    int b, p;
    burst(29'h1000, 7, 1'b0, 0, 0, 2'b00, b, p);
    n_vec++;
    if (b !== 8) begin n_err++; $display("FAIL basic_beats: got %0d want 8", b); end
  endtask

  task automatic test_len0;
    int b, p;
    burst(29'h2040, 0, 1'b0, 0, 0, 2'b00, b, p);
    n_vec++;
    if (b !== 1) begin n_err++; $display("FAIL len0_beats: got %0d want 1", b); end
  endtask

  task automatic test_stall;
    int b, p;
    burst(29'h3000, 3, 1'b1, 1, 3, 2'b00, b, p);
    n_vec++;
    if (b !== 4 || p !== 4) begin
      n_err++; $display("FAIL stall_count: got beats=%0d pops=%0d want 4 4", b, p);
    end
  endtask

  task automatic test_pend;
    int b, p;
    @(negedge clk);
    pend_in = 1'b1; write_req = 1'b1; req_addr = 29'h4000; req_len = 9'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (req_resp !== 1'b0 || axi_awvalid !== 1'b0 || pend_out !== 1'b0) begin
        n_err++;
        $display("FAIL pend_hold cyc=%0d: got resp=%b awv=%b pend=%b want 0 0 0",
                 i, req_resp, axi_awvalid, pend_out);
      end
      @(negedge clk);
    end
    burst(29'h4000, 2, 1'b0, 0, 0, 2'b00, b, p);
  endtask

  task automatic test_bresp;
    int b, p;
    burst(29'h5000, 1, 1'b0, 0, 0, 2'b10, b, p);
    burst(29'h5100, 1, 1'b0, 0, 0, 2'b00, b, p);
  endtask

  task automatic test_maxlen;
    int b, p;
    burst(29'h6000, 511, 1'b0, 0, 0, 2'b00, b, p);
    n_vec++;
    if (b !== 512) begin n_err++; $display("FAIL maxlen_beats: got %0d want 512", b); end
  endtask

  task automatic test_back_to_back;
    int b, p;
    burst(29'h7000, 1, 1'b0, 0, 0, 2'b00, b, p);
    write_req = 1'b1; req_addr = 29'h7100; req_len = 9'd2;
    #1;
    n_vec++;
    if (req_resp !== 1'b0) begin
      n_err++; $display("FAIL b2b_done_cycle: got req_resp=%b want 0", req_resp);
    end
    burst(29'h7100, 2, 1'b0, 0, 0, 2'b00, b, p);
  endtask

  task automatic test_reset_mid;
    int b, p;
    @(negedge clk);
    write_req = 1'b1; req_addr = 29'h8000; req_len = 9'd7;
    @(negedge clk);
    write_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      ivalid = 1'b1; idata = $urandom; axi_wready = 1'b1;
    end
    @(negedge clk);
    axi_resetn = 1'b0;
    #1;
    n_vec++;
    if ({axi_awvalid, axi_wvalid, axi_bready, pend_out, iready, req_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid: got awv/wv/brdy/pend/irdy/done=%b want 000000",
               {axi_awvalid, axi_wvalid, axi_bready, pend_out, iready, req_done});
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (req_done !== 1'b0 || pend_out !== 1'b0) begin
        n_err++; $display("FAIL reset_hold: got done=%b pend=%b want 0 0", req_done, pend_out);
      end
    end
    ivalid = 1'b0;
    axi_resetn = 1'b1;
    burst(29'h8800, 4, 1'b0, 0, 0, 2'b00, b, p);
    n_vec++;
    if (b !== 5) begin n_err++; $display("FAIL after_reset_beats: got %0d want 5", b); end
  endtask

  initial begin
    axi_resetn = 1'b0; write_req = 1'b0; req_len = '0; req_addr = '0;
    pend_in = 1'b0; idata = '0; ivalid = 1'b0;
    axi_awready = 1'b1; axi_wready = 1'b0;
    axi_bid = '0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_pend();
    test_bresp();
    test_maxlen();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_inf_write_state_core.md
Name: axi_inf_write_state_core

Overview:
- AXI4 write-channel master core for the VDMA write path (memory-side counterpart of the read state core).
- Accepts one burst request (address + length) at a time from the write FIFO status controller.
- Issues the AW transfer, streams exactly the requested beats from the upstream stream FIFO onto W with WLAST, then consumes the B response and signals completion.
- Shares the pend_in/pend_out arbitration convention with the read core, so read and write bursts to one port are serialised.

Parameters:
- IDSIZE, 4, width of AWID/BID.
- ID, 0, constant value driven on AWID.
- LSIZE, 9, width of req_len and AWLEN.
- ASIZE, 29, address width.
- DSIZE, 256, AXI data width; must be a power of two, 8 to 1024.

Ports:
- axi_aclk in 1: single clock for all logic.
- axi_resetn in 1: asynchronous active-low reset.
- write_req in 1: burst request level, sampled only in IDLE.
- req_len in LSIZE: beats minus 1 (AXI convention).
- req_addr in ASIZE: burst start byte address.
- req_resp out 1: one-cycle pulse when the request is accepted.
- req_done out 1: one-cycle pulse when the B response is consumed.
- resp_err out 1: one-cycle pulse, coincident with req_done, when BRESP != OKAY.
- pend_in in 1: other core busy; blocks new requests.
- pend_out out 1: this core busy.
- idata in DSIZE: upstream data.
- ivalid in 1: upstream data valid.
- iready out 1: upstream pop strobe.
- axi_awid out IDSIZE.
- axi_awaddr out ASIZE.
- axi_awlen out LSIZE.
- axi_awsize out 3.
- axi_awburst out 2.
- axi_awlock out 1.
- axi_awcache out 4.
- axi_awprot out 3.
- axi_awqos out 4.
- axi_awvalid out 1.
- axi_awready in 1.
- axi_wdata out DSIZE.
- axi_wstrb out DSIZE/8.
- axi_wlast out 1.
- axi_wvalid out 1.
- axi_wready in 1.
- axi_bid in IDSIZE.
- axi_bresp in 2.
- axi_bvalid in 1.
- axi_bready out 1.

Behaviour:
- Constant outputs:
  - awid=ID; awsize=log2(DSIZE/8), e.g. 3'b101 at 256 bits; awburst=2'b01 (INCR); awlock=0; awcache=4'b0011; awprot=0; awqos=0.
  - wstrb all ones.
- Reset (async assert, sync release): state=IDLE. awvalid, wvalid, wlast, bready, req_resp, req_done, resp_err, pend_out, iready all 0; beat counter 0; awaddr/awlen 0. Reset mid-burst abandons the burst immediately with no completion pulse.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE:
  - if write_req && !pend_in: register req_addr→awaddr and req_len→awlen, pulse req_resp for 1 cycle, go to ADDR.
  - write_req while pend_in=1 is held off; no req_resp.
- ADDR:
  - awvalid=1, pend_out=1.
  - On awvalid&&awready: drop awvalid next cycle, clear beat counter, go to DATA.
  - awaddr/awlen stay stable while awvalid=1.
- DATA:
  - Combinational pass-through: wvalid=ivalid, wdata=idata, iready=wready.
  - Beat counter (LSIZE bits) increments on wvalid&&wready.
  - wlast = (counter==awlen) && wvalid.
  - On the handshake with wlast=1, go to RESP.
  - No beat is popped outside DATA: iready=0 in every other state.
- RESP:
  - bready=1.
  - On bvalid: capture (bresp!=2'b00) into the error flag, go to DONE. bid is ignored.
- DONE:
  - Pulse req_done for 1 cycle; resp_err pulses in the same cycle if the error flag was set.
  - pend_out drops; return to IDLE.
- pend_out = 1 in ADDR, DATA and RESP.
- Minimum request-to-request spacing: a new request can be accepted the cycle after DONE.
- Latency with zero-wait slave: req_resp at T, awvalid T+1..T+1, first W beat T+2, last beat T+2+len, B earliest the next cycle, req_done one cycle after the B handshake.
- Boundary conditions:
  - len=0 gives a single beat with wlast=1.
  - len=2^LSIZE-1 runs the counter up to its maximum without wrap.
  - ivalid gaps and wready stalls only pause the counter.
  - write_req held high across DONE is re-accepted in IDLE as a new request.

Test Plan:
- Zero-wait slave, req_addr=0x1000, req_len=7, ivalid=1 → awaddr=0x1000, awlen=7, 8 W beats, wlast only on beat 8, bready until bvalid; req_resp once, req_done once, resp_err=0.
- req_len=0 → one W beat with wlast=1 in the same cycle; req_done after B.
- wready toggling 1010…, ivalid gap of 3 cycles, req_len=3 → exactly 4 beats transferred, data order preserved, no extra iready pops.
- pend_in=1 while write_req=1 for 5 cycles, then pend_in=0 → no req_resp and no awvalid during the hold; accepted on the first cycle pend_in=0.
- bresp=2'b10 → resp_err=1 in the same cycle as req_done; next burst with OKAY → resp_err=0.
- axi_resetn asserted in DATA after beat 2 of 8 → awvalid, wvalid, bready, pend_out all 0 immediately; no req_done; a fresh request after release completes normally.
